// File: rtl/fir_mac_filter_pkg.sv
// fir_pkg: shared types and elaboration-time helpers for the FIR MAC filter.
//   state_t : control FSM states (IDLE -> MAC -> RND -> OUT -> IDLE)
//   clog2   : ceil(log2(n)), used for counter and address widths
//   acc_w   : accumulator width that cannot overflow for NTAPS full-width products
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, RND, OUT} state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int acc_w(input int dw, input int cw, input int ntaps);
    return dw + cw + clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_mac_filter_if.sv
// fir_mac_filter_if: sample stream (valid/ready both sides) plus coefficient write port.
//   master : upstream/control side (drives in_*, out_ready, coef_we/addr/wdata)
//   slave  : filter side (drives in_ready, out_valid, out_data, coef_err)
// The coefficient address carries one code beyond the last tap so that
// out-of-range writes are representable and can be flagged.
interface fir_mac_filter_if
  import fir_pkg::*;
#(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int NTAPS = 4
);
  localparam int AW = clog2(NTAPS + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_wdata;
  logic                 coef_err;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, coef_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, coef_err
  );

endinterface

// File: rtl/fir_mac_filter_round_sat.sv
// fir_round_sat: combinational round-half-up, arithmetic right shift by
// OUT_SHIFT, then saturation to the signed DW-bit range.
//   i_acc  : signed ACCW-bit accumulator value
//   o_data : signed DW-bit result (registered by the parent)
module fir_round_sat #(
  parameter int ACCW      = 18,
  parameter int DW        = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACCW-1:0] i_acc,
  output logic signed [DW-1:0]   o_data
);

  // One guard bit so adding the rounding bias can never wrap.
  localparam logic signed [ACCW:0] MAXV = {{(ACCW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW:0] MINV = {{(ACCW-DW+2){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [ACCW:0] round_shift(input logic signed [ACCW-1:0] a);
    logic signed [ACCW:0] bias;
    logic signed [ACCW:0] sum;
    bias = '0;
    // Half an output LSB; stays zero when no shift is applied.
    for (int i = 0; i <= ACCW; i++)
      if (i == OUT_SHIFT - 1) bias[i] = 1'b1;
    sum = $signed({a[ACCW-1], a}) + bias;
    return sum >>> OUT_SHIFT;
  endfunction

  function automatic logic signed [DW-1:0] saturate(input logic signed [ACCW:0] v);
    if (v > MAXV)      return MAXV[DW-1:0];
    else if (v < MINV) return MINV[DW-1:0];
    else               return v[DW-1:0];
  endfunction

  assign o_data = saturate(round_shift(i_acc));

endmodule

// File: rtl/fir_mac_filter.sv
// fir_mac_filter: N-tap signed FIR with runtime-loadable coefficients and a
// single multiplier shared across taps (one product per cycle).
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (release synchronised upstream)
//   bus     : fir_mac_filter_if.slave -- sample in/out handshakes, coef writes
// One sample is in flight at a time: accept (IDLE), NTAPS MAC cycles, one
// round/saturate cycle, then OUT holds the result until the sink takes it.
module fir_mac_filter
  import fir_pkg::*;
#(
  parameter int DW        = 8,
  parameter int CW        = 8,
  parameter int NTAPS     = 4,
  parameter int OUT_SHIFT = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  fir_mac_filter_if.slave bus
);

  localparam int ACCW = acc_w(DW, CW, NTAPS);
  localparam int CNTW = clog2(NTAPS);
  localparam int AW   = clog2(NTAPS + 1);
  localparam int PW   = DW + CW;

  state_t                 r_state;
  state_t                 w_next;
  logic signed [DW-1:0]   r_dline [NTAPS];
  logic signed [CW-1:0]   r_coef  [NTAPS];
  logic [CNTW-1:0]        r_cnt;
  logic signed [ACCW-1:0] r_acc;
  logic signed [DW-1:0]   r_out_data;
  logic                   r_coef_err;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_last_tap;
  logic                   w_coef_ok;
  logic signed [PW-1:0]   w_d;
  logic signed [PW-1:0]   w_c;
  logic signed [PW-1:0]   w_prod;
  logic signed [ACCW-1:0] w_prod_ext;
  logic signed [DW-1:0]   w_rs;

  // in_ready is forced low while reset is asserted, and rises in the first
  // cycle after release without waiting for a clock edge.
  assign w_in_ready = (r_state == IDLE) && reset_n;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last_tap = (r_cnt == CNTW'(NTAPS - 1));
  assign w_coef_ok  = (r_state == IDLE) && (bus.coef_addr < AW'(NTAPS));

  // Shared multiplier: operands sign-extended to full product width first.
  assign w_d        = $signed({{CW{r_dline[r_cnt][DW-1]}}, r_dline[r_cnt]});
  assign w_c        = $signed({{DW{r_coef[r_cnt][CW-1]}}, r_coef[r_cnt]});
  assign w_prod     = w_d * w_c;
  assign w_prod_ext = {{(ACCW-PW){w_prod[PW-1]}}, w_prod};

  fir_round_sat #(
    .ACCW      (ACCW),
    .DW        (DW),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_round_sat (
    .i_acc  (r_acc),
    .o_data (w_rs)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)      w_next = MAC;
      MAC:     if (w_last_tap)    w_next = RND;
      RND:                        w_next = OUT;
      OUT:     if (bus.out_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_dline[k] <= '0;
        r_coef[k]  <= '0;
      end
      r_cnt      <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_coef_err <= 1'b0;
    end else begin
      r_coef_err <= bus.coef_we && !w_coef_ok;
      // A write on the accept edge lands before the first MAC cycle reads it.
      if (bus.coef_we && w_coef_ok)
        r_coef[bus.coef_addr[CNTW-1:0]] <= bus.coef_wdata;

      if (w_accept) begin
        for (int k = NTAPS - 1; k > 0; k--)
          r_dline[k] <= r_dline[k-1];
        r_dline[0] <= bus.in_data;
        r_cnt      <= '0;
        r_acc      <= '0;
      end else if (r_state == MAC) begin
        r_acc <= r_acc + w_prod_ext;
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == RND) begin
        r_out_data <= w_rs;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == OUT);
  assign bus.out_data  = r_out_data;
  assign bus.coef_err  = r_coef_err;

endmodule

// File: tb/tb_fir_mac_filter.sv
// Bench for fir_mac_filter: two instances (OUT_SHIFT 0 and 1) driven in
// lockstep, checked against a plain-arithmetic convolution model.
module tb_fir_mac_filter;

  localparam int NT  = 4;
  localparam int LAT = NT + 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid, out_ready, coef_we;
  logic signed [7:0] in_data, coef_wdata;
  logic [2:0]        coef_addr;

  int checks = 0;
  int errors = 0;
  int mc [NT];
  int mh [NT];
  int exp0, exp1;

  always #5 clk = ~clk;

  fir_mac_filter_if #(.DW(8), .CW(8), .NTAPS(NT)) if0 ();
  fir_mac_filter_if #(.DW(8), .CW(8), .NTAPS(NT)) if1 ();

  assign if0.in_valid   = in_valid;   assign if1.in_valid   = in_valid;
  assign if0.in_data    = in_data;    assign if1.in_data    = in_data;
  assign if0.out_ready  = out_ready;  assign if1.out_ready  = out_ready;
  assign if0.coef_we    = coef_we;    assign if1.coef_we    = coef_we;
  assign if0.coef_addr  = coef_addr;  assign if1.coef_addr  = coef_addr;
  assign if0.coef_wdata = coef_wdata; assign if1.coef_wdata = coef_wdata;

  fir_mac_filter #(.DW(8), .CW(8), .NTAPS(NT), .OUT_SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(if0.slave));
  fir_mac_filter #(.DW(8), .CW(8), .NTAPS(NT), .OUT_SHIFT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1.slave));

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: round half up, shift, clamp to signed 8 bits.
  function automatic int rs(input longint acc, input int sh);
    longint v;
    v = acc;
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NT; k++) begin mc[k] = 0; mh[k] = 0; end
  endtask

  task automatic model_accept(input int x);
    longint acc;
    acc = 0;
    for (int k = NT - 1; k > 0; k--) mh[k] = mh[k-1];
    mh[0] = x;
    for (int k = 0; k < NT; k++) acc += longint'(mh[k]) * longint'(mc[k]);
    exp0 = rs(acc, 0);
    exp1 = rs(acc, 1);
  endtask

  task automatic send(input int x, input bit we, input int addr, input int data);
    int n;
    n = 0;
    @(negedge clk);
    while (!if0.in_ready && n < 60) begin @(negedge clk); n++; end
    chk("in_ready_before_send", if0.in_ready, 1);
    in_valid = 1'b1; in_data = 8'(x);
    coef_we = we; coef_addr = 3'(addr); coef_wdata = 8'(data);
    @(posedge clk);
    if (we && addr < NT) mc[addr] = data;
    model_accept(x);
    #1;
    in_valid = 1'b0; coef_we = 1'b0;
    if (we) chk("coef_err_same_edge", if0.coef_err, 0);
  endtask

  task automatic recv(input int hold, input bit chk_lat);
    int lat;
    lat = 0;
    out_ready = (hold == 0);
    while (lat < 60) begin
      @(negedge clk);
      if (if0.out_valid) break;
      @(posedge clk);
      lat++;
    end
    chk("out_valid_seen", if0.out_valid, 1);
    if (chk_lat) chk("latency", lat + 1, LAT);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_valid", if0.out_valid, 1);
      chk("bp_data", if0.out_data, exp0);
      chk("bp_in_ready", if0.in_ready, 0);
    end
    out_ready = 1'b1;
    chk("out_data_s0", if0.out_data, exp0);
    chk("out_data_s1", if1.out_data, exp1);
    chk("out_valid_s1", if1.out_valid, 1);
    @(posedge clk);
    #1;
    chk("valid_drops", if0.out_valid, 0);
    chk("idle_ready", if0.in_ready, 1);
  endtask

  task automatic xfer(input int x);
    send(x, 1'b0, 0, 0);
    recv(0, 1'b1);
  endtask

  task automatic wcoef(input int addr, input int data, input bit busy);
    bit ok;
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'(addr); coef_wdata = 8'(data);
    @(posedge clk);
    ok = !busy && addr < NT;
    if (ok) mc[addr] = data;
    #1;
    coef_we = 1'b0;
    chk("coef_err_pulse", if0.coef_err, !ok);
    chk("coef_err_pulse_s1", if1.coef_err, !ok);
    @(posedge clk);
    #1;
    chk("coef_err_one_cycle", if0.coef_err, 0);
  endtask

  task automatic load4(input int c0, input int c1, input int c2, input int c3);
    wcoef(0, c0, 1'b0); wcoef(1, c1, 1'b0);
    wcoef(2, c2, 1'b0); wcoef(3, c3, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_in_ready", if0.in_ready, 0);
    chk("rst_out_valid", if0.out_valid, 0);
    chk("rst_out_data", if0.out_data, 0);
    chk("rst_coef_err", if0.coef_err, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("release_in_ready", if0.in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    model_reset();
    do_reset();

    // Impulse response
    load4(1, 3, 3, 1);
    xfer(1); xfer(0); xfer(0); xfer(0); xfer(0);

    // Back-pressure, then a normal transfer right after release
    send(7, 1'b0, 0, 0); recv(5, 1'b0);
    xfer(0);

    // Write while busy is dropped; out-of-range write in IDLE is dropped
    send(2, 1'b0, 0, 0); wcoef(0, 5, 1'b1); recv(0, 1'b0);
    wcoef(4, 9, 1'b0);
    xfer(1);

    // Write on the accept edge is used by that sample
    send(3, 1'b1, 1, -2); recv(0, 1'b1);

    // Saturation both directions
    load4(127, 127, 127, 127);
    for (int i = 0; i < 4; i++) xfer(127);
    for (int i = 0; i < 4; i++) xfer(-128);

    // Rounding (checked on the OUT_SHIFT=1 instance)
    load4(1, 0, 0, 0);
    xfer(3); xfer(-3); xfer(1);

    // Reset mid-MAC clears coefficients
    send(5, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    do_reset();
    xfer(77);

    // Reset mid-MAC clears history
    load4(1, 3, 3, 1);
    send(9, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    do_reset();
    load4(1, 3, 3, 1);
    xfer(1); xfer(0); xfer(0); xfer(0); xfer(0);

    // Randomized coefficients, samples and sink stalls
    for (int r = 0; r < 3; r++) begin
      load4(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
            int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
      for (int s = 0; s < 8; s++) begin
        send(int'($urandom_range(255)) - 128, 1'b0, 0, 0);
        recv(int'($urandom_range(2)), 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
